// File: rtl/hsarb_pkg.sv
// Shared types and helpers for the hiscore RAM arbiter.
// The optional pause-ack timeout is built when HSARB_TIMEOUT_EN is defined.
package hsarb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREQ,
      S_SETTLE,
      S_OWN,
      S_WR,
      S_RD,
      S_REL
   } hsarb_state_t;

   localparam int HSARB_CNT_W = 12;

   // Truncates an integer parameter to a counter load value.
   function automatic logic [HSARB_CNT_W-1:0] hsarb_cnt_val(input int v);
      logic [31:0] t;
      t = 32'(v);
      return t[HSARB_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/hsarb_cnt.sv
// Loadable down-counter with zero flag, shared by the settle window,
// the read-latency wait and the pause-ack timeout.
module hsarb_cnt
   import hsarb_pkg::*;
#(
   parameter int W = HSARB_CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Hands the core's work RAM to the hiscore engine while the CPU is paused.
// Define HSARB_TIMEOUT_EN to abandon a session when the pause ack never arrives.
module hiscore_ram_arbiter
   import hsarb_pkg::*;
#(
   parameter int AW      = 11,
   parameter int RD_LAT  = 2,
   parameter int SETTLE  = 4,
   parameter int HOLD    = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          hs_req_valid,
   input  logic          hs_req_we,
   input  logic [AW-1:0] hs_req_addr,
   input  logic [7:0]    hs_req_wdata,
   output logic          hs_req_ready,
   output logic          hs_rsp_valid,
   output logic [7:0]    hs_rsp_rdata,
   output logic          cpu_pause_req,
   input  logic          cpu_paused,
   output logic          ram_access,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   output logic          ram_we,
   input  logic [7:0]    ram_rdata,
   output logic          err_timeout
);

   if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
      $error("hiscore_ram_arbiter: RD_LAT must be 1..7");
   end
   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("hiscore_ram_arbiter: SETTLE must be 1..15");
   end
   if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
      $error("hiscore_ram_arbiter: HOLD must be 1..255");
   end
   if (TIMEOUT < 1 || TIMEOUT > (1 << HSARB_CNT_W)) begin : g_bad_timeout
      $error("hiscore_ram_arbiter: TIMEOUT out of counter range");
   end

   localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

   hsarb_state_t            state_q, state_d;
   logic                    cnt_load, cnt_dec, cnt_zero;
   logic [HSARB_CNT_W-1:0]  cnt_val;
   logic [7:0]              idle_q, idle_d;
   logic                    drop_q, drop_d;
   logic [AW-1:0]           addr_q;
   logic [7:0]              wdata_q, rdata_q;
   logic                    rsp_valid_q;
   logic                    rd_done;

   hsarb_cnt #(.W(HSARB_CNT_W)) u_cnt (
      .clk_i      (clk_sys),
      .rst_n_i    (reset_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef HSARB_TIMEOUT_EN
   logic err_q, err_set;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = '0;
`ifdef HSARB_TIMEOUT_EN
      err_set  = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (hs_req_valid) begin
               state_d = S_PREQ;
`ifdef HSARB_TIMEOUT_EN
               cnt_load = 1'b1;
               cnt_val  = hsarb_cnt_val(TIMEOUT - 1);
`endif
            end
         end
         S_PREQ: begin
            if (cpu_paused) begin
               state_d  = S_SETTLE;
               cnt_load = 1'b1;
               cnt_val  = hsarb_cnt_val(SETTLE - 1);
            end
`ifdef HSARB_TIMEOUT_EN
            else if (cnt_zero) begin
               state_d = S_IDLE;
               err_set = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
`endif
         end
         S_SETTLE: begin
            if (!cpu_paused) begin
               state_d = S_REL;
            end else if (cnt_zero) begin
               state_d = S_OWN;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_OWN: begin
            if (hs_req_ready) begin
               state_d = hs_req_we ? S_WR : S_RD;
               if (!hs_req_we) begin
                  cnt_load = 1'b1;
                  cnt_val  = hsarb_cnt_val(RD_LAT - 1);
               end
            end else if (!cpu_paused || drop_q || (idle_q == HOLD_LAST)) begin
               state_d = S_REL;
            end
         end
         S_WR:    state_d = S_OWN;
         S_RD: begin
            if (cnt_zero) begin
               state_d = S_OWN;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_REL:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A lost pause ack is remembered until the session is released.
   always_comb begin
      drop_d = 1'b0;
      idle_d = '0;
      if (state_q inside {S_SETTLE, S_OWN, S_WR, S_RD}) begin
         drop_d = drop_q | ~cpu_paused;
      end
      if (state_q == S_OWN) begin
         if (hs_req_ready) begin
            idle_d = '0;
         end else if (idle_q != 8'hFF) begin
            idle_d = idle_q + 8'd1;
         end else begin
            idle_d = idle_q;
         end
      end else if (state_q inside {S_WR, S_RD}) begin
         idle_d = idle_q;
      end
   end

   // The response cycle blocks a new accept so reads are spaced RD_LAT+2 apart.
   always_comb begin
      cpu_pause_req = (state_q != S_IDLE);
      ram_access    = (state_q inside {S_OWN, S_WR, S_RD});
      ram_we        = (state_q == S_WR);
      hs_req_ready  = (state_q == S_OWN) && hs_req_valid && cpu_paused
                      && !drop_q && !rsp_valid_q;
      ram_addr      = hs_req_ready ? hs_req_addr : addr_q;
      ram_wdata     = wdata_q;
      hs_rsp_valid  = rsp_valid_q;
      hs_rsp_rdata  = rdata_q;
   end

   assign rd_done = (state_q == S_RD) && cnt_zero;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         idle_q      <= '0;
         drop_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         idle_q      <= idle_d;
         drop_q      <= drop_d;
         rsp_valid_q <= rd_done;
         if (hs_req_ready) begin
            addr_q  <= hs_req_addr;
            wdata_q <= hs_req_wdata;
         end
         if (rd_done) begin
            rdata_q <= ram_rdata;
         end
      end
   end

`ifdef HSARB_TIMEOUT_EN
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with a latency-accurate RAM model,
// a delayed pause-block model and expectation/observation queues.
`timescale 1ns/1ps
module tb_hiscore_ram_arbiter;
   import hsarb_pkg::*;

   localparam int AW      = 11;
   localparam int RD_LAT  = 2;
   localparam int SETTLE  = 4;
   localparam int HOLD    = 16;
   localparam int TIMEOUT = 64;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic          hs_req_valid, hs_req_we;
   logic [AW-1:0] hs_req_addr;
   logic [7:0]    hs_req_wdata;
   logic          hs_req_ready, hs_rsp_valid;
   logic [7:0]    hs_rsp_rdata;
   logic          cpu_pause_req, cpu_paused;
   logic          ram_access, ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata, ram_rdata;
   logic          err_timeout;

   hiscore_ram_arbiter #(
      .AW(AW), .RD_LAT(RD_LAT), .SETTLE(SETTLE), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .hs_req_valid  (hs_req_valid),
      .hs_req_we     (hs_req_we),
      .hs_req_addr   (hs_req_addr),
      .hs_req_wdata  (hs_req_wdata),
      .hs_req_ready  (hs_req_ready),
      .hs_rsp_valid  (hs_rsp_valid),
      .hs_rsp_rdata  (hs_rsp_rdata),
      .cpu_pause_req (cpu_pause_req),
      .cpu_paused    (cpu_paused),
      .ram_access    (ram_access),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .ram_we        (ram_we),
      .ram_rdata     (ram_rdata),
      .err_timeout   (err_timeout)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   function automatic logic [7:0] pattern(input int a);
      return 8'((a * 37 + 11) & 255);
   endfunction

   // RAM: RD_LAT-deep read pipeline, writes only while the hiscore side owns it
   logic [7:0] mem  [0:2047];
   logic [7:0] pipe [0:RD_LAT-1];
   logic       mem_loaded = 1'b0;
   always @(posedge clk_sys) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 2048; i++) mem[i] <= pattern(i);
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= 8'h00;
         mem_loaded <= 1'b1;
      end else begin
         if (ram_access && ram_we) mem[ram_addr] <= ram_wdata;
         pipe[0] <= mem[ram_addr];
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign ram_rdata = pipe[RD_LAT-1];

   // Pause block: acknowledges 3 cycles after the request, with override knobs
   logic [2:0] pz;
   logic       drop_force = 1'b0;
   logic       hold0      = 1'b0;
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) pz <= 3'b000;
      else          pz <= {pz[1:0], cpu_pause_req};
   end
   assign cpu_paused = pz[2] & ~drop_force & ~hold0;

   typedef struct packed { logic [7:0] data; logic [31:0] cyc; } rd_t;
   typedef struct packed { logic [10:0] addr; logic [7:0] data; logic [31:0] cyc; } wr_t;
   rd_t rd_exp[$], rsp_obs[$];
   wr_t wr_exp[$], we_obs[$];
   int  sess_cnt = 0;
   logic pause_prev = 1'b0;

   always @(negedge clk_sys) begin
      if (reset_n) begin
         if (hs_rsp_valid) rsp_obs.push_back('{hs_rsp_rdata, 32'(cyc)});
         if (ram_we)       we_obs.push_back('{ram_addr, ram_wdata, 32'(cyc)});
         if (cpu_pause_req && !pause_prev) sess_cnt <= sess_cnt + 1;
      end
      pause_prev <= cpu_pause_req;
   end

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!hs_req_ready && n < 30) begin tick(); n++; end
      chk(tag, hs_req_ready, 1'b1);
   endtask

   task automatic drain(input string tag);
      int  n = 0;
      rd_t re, ro;
      wr_t we, wo;
      while ((rsp_obs.size() < rd_exp.size() || we_obs.size() < wr_exp.size()) && n < 50) begin
         tick(); n++;
      end
      chk({tag, "_rd_count"}, 32'(rsp_obs.size()), 32'(rd_exp.size()));
      chk({tag, "_wr_count"}, 32'(we_obs.size()), 32'(wr_exp.size()));
      while (rd_exp.size() > 0 && rsp_obs.size() > 0) begin
         re = rd_exp.pop_front(); ro = rsp_obs.pop_front();
         chk({tag, "_rd_data"}, 32'(ro.data), 32'(re.data));
         chk({tag, "_rd_cycle"}, ro.cyc, re.cyc);
      end
      while (wr_exp.size() > 0 && we_obs.size() > 0) begin
         we = wr_exp.pop_front(); wo = we_obs.pop_front();
         chk({tag, "_wr_addr"}, 32'(wo.addr), 32'(we.addr));
         chk({tag, "_wr_data"}, 32'(wo.data), 32'(we.data));
         chk({tag, "_wr_cycle"}, wo.cyc, we.cyc);
      end
      rd_exp.delete(); rsp_obs.delete(); wr_exp.delete(); we_obs.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, ta, n, s0;
      logic acc_seen;
      hs_req_valid = 1'b0; hs_req_we = 1'b0; hs_req_addr = '0; hs_req_wdata = '0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_pause_req", cpu_pause_req, 1'b0);
      chk("rst_ram_access", ram_access, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ready", hs_req_ready, 1'b0);
      chk("rst_rsp_valid", hs_rsp_valid, 1'b0);
      chk("rst_rsp_rdata", 32'(hs_rsp_rdata), 32'h0);
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_err", err_timeout, 1'b0);
      reset_n = 1'b1;
      tick(); tick();

      // Read 0x123: ack 3 cycles after the request, 4 settle cycles, then own
      hs_req_we = 1'b0; hs_req_addr = 11'h123; hs_req_valid = 1'b1; t0 = cyc;
      chk("t1_idle_pause", cpu_pause_req, 1'b0);
      tick();
      chk("t1_preq_pause", cpu_pause_req, 1'b1);
      chk("t1_preq_ready", hs_req_ready, 1'b0);
      n = 0;
      while (!ram_access && n < 20) begin tick(); n++; end
      chk("t1_own_cycle", 32'(cyc - t0), 32'd9);
      chk("t1_own_ready", hs_req_ready, 1'b1);
      ta = cyc;
      rd_exp.push_back('{pattern(12'h123), 32'(ta + RD_LAT + 1)});
      tick();
      hs_req_valid = 1'b0;
      chk("t1_rd_ready", hs_req_ready, 1'b0);
      drain("t1");

      // Hold: 16 idle cycles in OWN after the response, then one REL cycle
      n = 0;
      while (ram_access && n < 40) begin tick(); n++; end
      chk("t3_rel_cycle", 32'(cyc - (ta + RD_LAT + 1)), 32'(HOLD));
      chk("t3_rel_pause", cpu_pause_req, 1'b1);
      tick();
      chk("t3_idle_pause", cpu_pause_req, 1'b0);
      chk("t3_idle_access", ram_access, 1'b0);

      // Back-to-back writes in one session
      repeat (6) tick();
      s0 = sess_cnt;
      hs_req_we = 1'b1; hs_req_addr = 11'h7FF; hs_req_wdata = 8'hA5; hs_req_valid = 1'b1;
      wait_ready("t2_ready1");
      wr_exp.push_back('{11'h7FF, 8'hA5, 32'(cyc + 1)});
      tick();
      chk("t2_wr_ready", hs_req_ready, 1'b0);
      chk("t2_wr_we", ram_we, 1'b1);
      hs_req_addr = 11'h000; hs_req_wdata = 8'h5A;
      tick();
      chk("t2_ready2", hs_req_ready, 1'b1);
      chk("t2_own_we", ram_we, 1'b0);
      wr_exp.push_back('{11'h000, 8'h5A, 32'(cyc + 1)});
      tick();
      hs_req_valid = 1'b0;
      n = 0;
      while (cpu_pause_req && n < 40) begin tick(); n++; end
      chk("t2_sessions", 32'(sess_cnt - s0), 32'd1);
      chk("t2_mem_7ff", 32'(mem[11'h7FF]), 32'hA5);
      chk("t2_mem_000", 32'(mem[11'h000]), 32'h5A);
      drain("t2");

      // Ack drops during RD; a new valid on another address must not be taken
      repeat (6) tick();
      hs_req_we = 1'b0; hs_req_addr = 11'h7FF; hs_req_valid = 1'b1;
      wait_ready("t4_ready");
      rd_exp.push_back('{8'hA5, 32'(cyc + RD_LAT + 1)});
      tick();
      drop_force = 1'b1;
      hs_req_addr = 11'h000;
      chk("t4_rd1_ready", hs_req_ready, 1'b0);
      tick();
      chk("t4_rd2_ready", hs_req_ready, 1'b0);
      tick();
      chk("t4_own_ready", hs_req_ready, 1'b0);
      chk("t4_own_rsp", hs_rsp_valid, 1'b1);
      tick();
      chk("t4_rel_access", ram_access, 1'b0);
      chk("t4_rel_pause", cpu_pause_req, 1'b1);
      chk("t4_rel_ready", hs_req_ready, 1'b0);
      hs_req_valid = 1'b0;
      tick();
      chk("t4_idle_pause", cpu_pause_req, 1'b0);
      drop_force = 1'b0;
      drain("t4");

      // Reset asserted in the middle of a WR cycle
      repeat (6) tick();
      hs_req_we = 1'b1; hs_req_addr = 11'h055; hs_req_wdata = 8'h77; hs_req_valid = 1'b1;
      wait_ready("t5_ready");
      tick();
      chk("t5_wr_we", ram_we, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_rst_we", ram_we, 1'b0);
      chk("t5_rst_access", ram_access, 1'b0);
      chk("t5_rst_pause", cpu_pause_req, 1'b0);
      chk("t5_rst_state", 32'(dut.state_q), 32'(S_IDLE));
      hs_req_valid = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      chk("t5_no_write", 32'(mem[11'h055]), 32'(pattern(12'h055)));
      chk("t5_post_state", 32'(dut.state_q), 32'(S_IDLE));
      rd_exp.delete(); wr_exp.delete(); rsp_obs.delete(); we_obs.delete();

`ifdef HSARB_TIMEOUT_EN
      // Pause ack never arrives
      repeat (6) tick();
      hold0 = 1'b1;
      hs_req_we = 1'b0; hs_req_addr = 11'h010; hs_req_valid = 1'b1; t0 = cyc;
      acc_seen = 1'b0;
      tick();
      n = 0;
      while (!err_timeout && n < 100) begin
         if (ram_access) acc_seen = 1'b1;
         tick(); n++;
      end
      hs_req_valid = 1'b0;
      chk("t6_err_cycle", 32'(cyc - t0), 32'(TIMEOUT + 1));
      chk("t6_err", err_timeout, 1'b1);
      chk("t6_pause", cpu_pause_req, 1'b0);
      chk("t6_no_access", acc_seen, 1'b0);
      repeat (3) tick();
      chk("t6_err_sticky", err_timeout, 1'b1);
      chk("t6_idle_access", ram_access, 1'b0);
      hold0 = 1'b0;
`else
      acc_seen = 1'b0;
      chk("t6_err_tied", err_timeout, acc_seen);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
